// File: rtl/image_pkg.sv
// Shared types and constants for the camera frame sequencer and its RGB byte packer.
package image_pkg;

    typedef enum logic [1:0] {StIdle, StStream, StDrain} frame_state_t;

    localparam int unsigned DefaultN    = 480;
    localparam int unsigned DefaultM    = 320;
    localparam int unsigned BytesPerPix = 3;

    // Byte order within a pixel; R arrives first and lands in the top lane of {R,G,B}.
    localparam logic [1:0] PhaseR = 2'd0;
    localparam logic [1:0] PhaseG = 2'd1;
    localparam logic [1:0] PhaseB = 2'd2;

    function automatic logic [23:0] insert_byte(input logic [23:0] acc,
                                                input logic [1:0]  phase,
                                                input logic [7:0]  b);
        logic [23:0] r;
        r = acc;
        case (phase)
            PhaseR:  r[23:16] = b;
            PhaseG:  r[15:8]  = b;
            default: r[7:0]   = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rgb_packer.sv
// Packs the R,G,B byte stream into 24-bit pixels with x/y coordinates and sof/eol/eof flags.
module rgb_packer
    import image_pkg::*;
#(
    parameter int unsigned N = DefaultN,
    parameter int unsigned M = DefaultM,
    localparam int unsigned XW = (N > 1) ? $clog2(N) : 1,
    localparam int unsigned YW = (M > 1) ? $clog2(M) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear_i,
    input  logic          byte_valid_i,
    input  logic [7:0]    byte_i,
    output logic          pix_valid_o,
    output logic [23:0]   pix_rgb_o,
    output logic [XW-1:0] pix_x_o,
    output logic [YW-1:0] pix_y_o,
    output logic          pix_sof_o,
    output logic          pix_eol_o,
    output logic          pix_eof_o,
    output logic          frame_end_o
);

    logic [1:0]    phase_q;
    logic [23:0]   acc_q;
    logic [23:0]   acc_d;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic          emit;
    logic          last_x;
    logic          last_y;

    assign acc_d       = insert_byte(acc_q, phase_q, byte_i);
    assign emit        = byte_valid_i && (phase_q == PhaseB);
    assign last_x      = (x_q == XW'(N - 1));
    assign last_y      = (y_q == YW'(M - 1));
    assign frame_end_o = emit && last_x && last_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q     <= PhaseR;
            acc_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            pix_valid_o <= 1'b0;
            pix_rgb_o   <= '0;
            pix_x_o     <= '0;
            pix_y_o     <= '0;
            pix_sof_o   <= 1'b0;
            pix_eol_o   <= 1'b0;
            pix_eof_o   <= 1'b0;
        end else begin
            // A pixel completed on the same cycle as clear is still whole, so it is emitted.
            pix_valid_o <= emit;
            pix_sof_o   <= emit && (x_q == '0) && (y_q == '0);
            pix_eol_o   <= emit && last_x;
            pix_eof_o   <= emit && last_x && last_y;
            if (emit) begin
                pix_rgb_o <= acc_d;
                pix_x_o   <= x_q;
                pix_y_o   <= y_q;
            end

            if (clear_i) begin
                phase_q <= PhaseR;
                x_q     <= '0;
                y_q     <= '0;
            end else if (byte_valid_i) begin
                acc_q <= acc_d;
                if (phase_q == PhaseB) begin
                    phase_q <= PhaseR;
                    if (last_x) begin
                        x_q <= '0;
                        y_q <= last_y ? '0 : y_q + 1'b1;
                    end else begin
                        x_q <= x_q + 1'b1;
                    end
                end else begin
                    phase_q <= phase_q + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/image_frame_ctrl.sv
// Frame sequencer: drives camera_en for one 3*N*M-cycle frame per request and packs returned bytes.
module image_frame_ctrl
    import image_pkg::*;
#(
    parameter int unsigned N = DefaultN,
    parameter int unsigned M = DefaultM,
    localparam int unsigned XW = (N > 1) ? $clog2(N) : 1,
    localparam int unsigned YW = (M > 1) ? $clog2(M) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          continuous,
    input  logic          abort,
    output logic          camera_en,
    input  logic          cam_valid,
    input  logic [7:0]    cam_data,
    output logic          pix_valid,
    output logic [23:0]   pix_rgb,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic          pix_sof,
    output logic          pix_eol,
    output logic          pix_eof,
    output logic          busy,
    output logic          frame_done,
    output logic          seq_err,
    output logic [15:0]   frame_cnt
);

    localparam int unsigned EnTotal = BytesPerPix * N * M;
    localparam int unsigned EnW     = (EnTotal > 1) ? $clog2(EnTotal) : 1;
    localparam logic [EnW-1:0] EnLast = EnW'(EnTotal - 1);

    frame_state_t   state_q;
    logic [EnW-1:0] en_cnt_q;
    logic           camera_en_q;
    logic           exp_q;
    logic           seq_err_q;
    logic [15:0]    frame_cnt_q;

    logic proto_err;
    logic abort_eff;
    logic accept;
    logic start_ok;
    logic frame_end;

    assign proto_err = exp_q && !cam_valid;
    assign abort_eff = (state_q != StIdle) && (abort || proto_err);
    assign accept    = exp_q && cam_valid;
    assign start_ok  = (state_q == StIdle) && start && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            en_cnt_q    <= '0;
            camera_en_q <= 1'b0;
            exp_q       <= 1'b0;
            seq_err_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            // Killing exp on abort makes the byte already in flight from the source ignored.
            exp_q <= camera_en_q && !abort_eff;
            if (frame_end) frame_cnt_q <= frame_cnt_q + 16'd1;
            if (proto_err) seq_err_q <= 1'b1;
            case (state_q)
                StIdle: begin
                    if (start_ok) begin
                        state_q     <= StStream;
                        camera_en_q <= 1'b1;
                        en_cnt_q    <= '0;
                        seq_err_q   <= 1'b0;
                    end
                end
                StStream: begin
                    if (abort_eff) begin
                        state_q     <= StIdle;
                        camera_en_q <= 1'b0;
                    end else if (en_cnt_q == EnLast) begin
                        state_q     <= StDrain;
                        camera_en_q <= 1'b0;
                    end else begin
                        en_cnt_q <= en_cnt_q + 1'b1;
                    end
                end
                StDrain: begin
                    if (!abort_eff && continuous) begin
                        state_q     <= StStream;
                        camera_en_q <= 1'b1;
                        en_cnt_q    <= '0;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    camera_en_q <= 1'b0;
                end
            endcase
        end
    end

    rgb_packer #(
        .N (N),
        .M (M)
    ) u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (start_ok || abort_eff),
        .byte_valid_i (accept),
        .byte_i       (cam_data),
        .pix_valid_o  (pix_valid),
        .pix_rgb_o    (pix_rgb),
        .pix_x_o      (pix_x),
        .pix_y_o      (pix_y),
        .pix_sof_o    (pix_sof),
        .pix_eol_o    (pix_eol),
        .pix_eof_o    (pix_eof),
        .frame_end_o  (frame_end)
    );

    assign camera_en  = camera_en_q;
    assign busy       = (state_q != StIdle);
    assign frame_done = pix_valid && pix_eof;
    assign seq_err    = seq_err_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: doc/image_frame_ctrl.md
# image_frame_ctrl

Frame sequencer for the camera/image byte source. Owns the source's `camera_en` and issues exactly one full frame of 3·N·M enable cycles per request. Packs the returned byte stream into 24-bit RGB pixels tagged with x/y coordinates and frame/line markers for the downstream pixel pipeline. Sits between the frame-request logic and the first pixel-processing stage.

## Interface
Parameters:
- `N`, default 480: pixels per line (x range 0..N-1)
- `M`, default 320: lines per frame (y range 0..M-1)

Ports:
- `clk` in 1: single clock; all logic on the rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `start` in 1: single-cycle frame request; sampled only in IDLE
- `continuous` in 1: when 1 at end of frame, the next frame starts automatically
- `abort` in 1: terminate the current frame
- `camera_en` out 1: enable to the image source
- `cam_valid` in 1: source `data_valid`
- `cam_data` in 8: source `data_out`
- `pix_valid` out 1: pixel strobe
- `pix_rgb` out 24: {R,G,B}
- `pix_x` out clog2(N): column
- `pix_y` out clog2(M): line
- `pix_sof`, `pix_eol`, `pix_eof` out 1 each: first pixel of frame, last pixel of line, last pixel of frame; valid only with `pix_valid`
- `busy` out 1: state != IDLE
- `frame_done` out 1: one-cycle pulse coincident with the `pix_eof` beat
- `seq_err` out 1: sticky source-protocol error; cleared by the next accepted `start`
- `frame_cnt` out 16: completed frames, wraps at 2^16

## Operation
- States: IDLE, STREAM, DRAIN.
- **IDLE**
  - `camera_en` = 0.
  - `start`=1 and `abort`=0: clear `seq_err`, clear counters, go to STREAM.
- **STREAM**
  - `camera_en` = 1 every cycle.
  - Enable counter counts issued enables, 0..3NM-1.
  - On the cycle that issues enable 3NM-1, go to DRAIN.
- **DRAIN**
  - `camera_en` = 0 for exactly one cycle, which resets the source pointer.
  - Then go to STREAM if `continuous`=1, else IDLE.
  - Consecutive frames therefore have exactly one gap cycle.
- **Byte expectation:** `exp` = `camera_en` registered one cycle.
  - `exp`=1 and `cam_valid`=0: set `seq_err` and act as abort.
  - `cam_valid`=1 while `exp`=0: ignore the byte.
- **Byte packing:**
  - Byte-phase counter runs 0,1,2 → R,G,B.
  - On the B byte, emit the pixel and advance x.
  - x wraps at N-1 and increments y; y wraps at M-1.
- **Flags:**
  - `pix_sof` when x=0, y=0.
  - `pix_eol` when x=N-1.
  - `pix_eof` when x=N-1, y=M-1. `frame_cnt` increments on this beat.
- **Abort** (`abort`=1 in STREAM/DRAIN, or a protocol error):
  - Next cycle: `camera_en`=0, state IDLE.
  - Partial pixel discarded, x/y/phase cleared.
  - No `pix_eof`, no `frame_done`, `frame_cnt` unchanged.
  - An in-flight byte arriving the cycle after abort is ignored.
- **Simultaneous events:**
  - `start` outside IDLE is ignored.
  - `start`+`abort` in IDLE: `abort` wins.
  - `abort` on the DRAIN cycle: return to IDLE even if `continuous`=1. The completed frame's `pix_eof`/`frame_done` still fire.
- Counter widths: enable counter clog2(3NM) bits; no arithmetic overflow is permitted within a frame.

## Timing
- Reset values:
  - `camera_en`, `pix_valid`, `pix_sof`, `pix_eol`, `pix_eof`, `busy`, `frame_done`, `seq_err`: 0
  - `pix_rgb`, `pix_x`, `pix_y`, `frame_cnt`: 0
  - state = IDLE
- `start` sampled at edge k → `camera_en`=1 from cycle k+1; first source byte at k+2.
- Pixel latency: the B byte accepted at edge t → `pix_valid`, `pix_rgb`, coordinates and flags registered at edge t+1.
- Frame length: STREAM spans 3NM cycles. The last byte arrives on the DRAIN cycle; `pix_eof` follows one cycle later, which is the first cycle of the next STREAM or IDLE.
- `pix_valid` is high one cycle in three during steady stream.
- No backpressure: downstream must accept every `pix_valid` beat.

## Structure
- Shared package `image_pkg`:
  - state enum `frame_state_t` {IDLE, STREAM, DRAIN}
  - default N/M constants
  - `BYTES_PER_PIX`=3
  - RGB packing order constant
- One sub-module: `rgb_packer`, covering byte-phase counter, 24-bit assembly, x/y counters and flag generation. It takes `byte_valid`, `byte`, `clear` and produces the pixel outputs. The top level holds the FSM, enable counter, `exp` tracking, `seq_err` and `frame_cnt`.

## Test plan
- N=4, M=2, single `start`, source model returns bytes 0x00..0x17 → `camera_en` high exactly 24 cycles; 8 pixels, first `pix_rgb`=0x000102, last 0x151617; `pix_eol` at x=3 for y=0 and y=1; one `pix_eof`; `frame_cnt`=1; `busy` low afterwards.
- `continuous`=1 for 3 frames → exactly one `camera_en`-low cycle between frames; `frame_cnt`=3; every frame's `pix_sof` pixel = 0x000102.
- `abort` asserted after 10 enables → `camera_en` low the next cycle; 3 pixels emitted, no `pix_eof`, `frame_cnt` unchanged; a following `start` streams a full clean frame.
- Source drops `cam_valid` for one cycle mid-frame → `seq_err`=1, frame aborted, `busy`=0; the next `start` clears `seq_err`.
- `start` pulsed mid-frame, and `start`+`abort` together in IDLE → both ignored; no extra frame, state unchanged.
- `rst_n` asserted mid-STREAM → all outputs 0 immediately (async); after release a `start` produces a correct frame from x=0, y=0.
